// File: rtl/tbb_bus_sequencer.sv
// tbb_bus_sequencer: queues register-write commands and plays each one out to a
// nibble-wide sound-core bus as three strobed nibbles (address, data low, data high).
//
// Ports
//   CLK        in   sole clock, rising edge
//   RST_N      in   synchronous active-low reset
//   CMD_VALID  in   command present on CMD_ADDR/CMD_DATA
//   CMD_READY  out  command FIFO has room this cycle
//   CMD_ADDR   in   [3:0] target register number
//   CMD_DATA   in   [7:0] register value
//   BUS_D      out  [3:0] nibble to the sound core (registered)
//   BUS_A0     out  1 = address nibble, 0 = data nibble (registered)
//   BUS_WR     out  write strobe, active-high (registered)
//   BUSY       out  FIFO non-empty or bus cycle in progress (registered)
module tbb_bus_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WR_WIDTH   = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [3:0] CMD_ADDR,
  input  logic [7:0] CMD_DATA,
  output logic [3:0] BUS_D,
  output logic       BUS_A0,
  output logic       BUS_WR,
  output logic       BUSY
);

  localparam int unsigned    PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned    CntW     = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [3:0]     WrLast   = 4'(WR_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

  state_e          state_q, state_d;
  logic [1:0]      ni_q, ni_d;
  logic [3:0]      wr_cnt_q, wr_cnt_d;
  logic [11:0]     cur_q, cur_d;

  logic [11:0]     mem_q [0:FIFO_DEPTH-1];
  logic [11:0]     mem_d [0:FIFO_DEPTH-1];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [3:0]      bus_d_q, bus_d_d;
  logic            bus_a0_q, bus_a0_d;
  logic            bus_wr_q, bus_wr_d;
  logic            busy_q, busy_d;

  logic            push, pop, fifo_nempty;
  logic [11:0]     head;

  // Ready depends on the registered count only, so a pop never frees a slot
  // combinationally in the same cycle.
  assign fifo_nempty = (count_q != '0);
  assign CMD_READY   = (count_q != DepthCnt);
  assign push        = CMD_VALID & CMD_READY & RST_N;
  assign head        = mem_q[rd_ptr_q];

  assign BUS_D  = bus_d_q;
  assign BUS_A0 = bus_a0_q;
  assign BUS_WR = bus_wr_q;
  assign BUSY   = busy_q;

  // Command word layout is {addr, data}; nibble order is addr, data[3:0], data[7:4].
  function automatic logic [4:0] nibble(input logic [11:0] cmd, input logic [1:0] ni);
    case (ni)
      2'd0:    nibble = {1'b1, cmd[11:8]};
      2'd1:    nibble = {1'b0, cmd[3:0]};
      default: nibble = {1'b0, cmd[7:4]};
    endcase
  endfunction

  // FIFO next state; depth is a power of two so pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {CMD_ADDR, CMD_DATA};
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Sequencer next state.
  always_comb begin
    state_d  = state_q;
    ni_d     = ni_q;
    wr_cnt_d = wr_cnt_q;
    cur_d    = cur_q;
    pop      = 1'b0;
    case (state_q)
      StIdle: begin
        if (fifo_nempty) begin
          pop     = 1'b1;
          cur_d   = head;
          ni_d    = 2'd0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        wr_cnt_d = 4'd0;
        state_d  = StStrobe;
      end
      StStrobe: begin
        if (wr_cnt_q == WrLast) begin
          state_d = StHold;
        end else begin
          wr_cnt_d = wr_cnt_q + 4'd1;
        end
      end
      StHold: begin
        if (ni_q != 2'd2) begin
          ni_d    = ni_q + 2'd1;
          state_d = StSetup;
        end else if (fifo_nempty) begin
          // Chain straight into the next command with no idle gap.
          pop     = 1'b1;
          cur_d   = head;
          ni_d    = 2'd0;
          state_d = StSetup;
        end else begin
          ni_d    = 2'd0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs are computed from the next state so they change on the
  // edge that enters SETUP or IDLE and stay frozen through STROBE and HOLD.
  always_comb begin
    bus_wr_d = (state_d == StStrobe);
    bus_a0_d = bus_a0_q;
    bus_d_d  = bus_d_q;
    if (state_d == StIdle) begin
      bus_a0_d = 1'b0;
      bus_d_d  = 4'd0;
    end else if (state_d == StSetup) begin
      {bus_a0_d, bus_d_d} = nibble(cur_d, ni_d);
    end
    busy_d = (state_d != StIdle) || (count_d != '0);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= StIdle;
      ni_q     <= 2'd0;
      wr_cnt_q <= 4'd0;
      cur_q    <= 12'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      bus_d_q  <= 4'd0;
      bus_a0_q <= 1'b0;
      bus_wr_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ni_q     <= ni_d;
      wr_cnt_q <= wr_cnt_d;
      cur_q    <= cur_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      bus_d_q  <= bus_d_d;
      bus_a0_q <= bus_a0_d;
      bus_wr_q <= bus_wr_d;
      busy_q   <= busy_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by the pointers and count.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_tbb_bus_sequencer.sv
module tb_tbb_bus_sequencer;

  localparam int W     = 2;
  localparam int DEPTH = 4;
  localparam int LEN   = 3 * (W + 2);

  logic       clk = 1'b0;
  logic       rst_n, cmd_valid, aux_valid;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       cmd_ready, bus_a0, bus_wr, busy;
  logic [3:0] bus_d;
  logic       w1_ready, w1_a0, w1_wr, w1_busy;
  logic [3:0] w1_d;
  logic       w15_ready, w15_a0, w15_wr, w15_busy;
  logic [3:0] w15_d;

  always #5 clk = ~clk;

  tbb_bus_sequencer #(.FIFO_DEPTH(DEPTH), .WR_WIDTH(W)) u_dut (
    .CLK(clk), .RST_N(rst_n), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
    .CMD_ADDR(cmd_addr), .CMD_DATA(cmd_data), .BUS_D(bus_d), .BUS_A0(bus_a0),
    .BUS_WR(bus_wr), .BUSY(busy)
  );

  tbb_bus_sequencer #(.FIFO_DEPTH(DEPTH), .WR_WIDTH(1)) u_w1 (
    .CLK(clk), .RST_N(rst_n), .CMD_VALID(aux_valid), .CMD_READY(w1_ready),
    .CMD_ADDR(4'h3), .CMD_DATA(8'h5C), .BUS_D(w1_d), .BUS_A0(w1_a0),
    .BUS_WR(w1_wr), .BUSY(w1_busy)
  );

  tbb_bus_sequencer #(.FIFO_DEPTH(DEPTH), .WR_WIDTH(15)) u_w15 (
    .CLK(clk), .RST_N(rst_n), .CMD_VALID(aux_valid), .CMD_READY(w15_ready),
    .CMD_ADDR(4'h3), .CMD_DATA(8'h5C), .BUS_D(w15_d), .BUS_A0(w15_a0),
    .BUS_WR(w15_wr), .BUSY(w15_busy)
  );

  // Reference model: a queue of pending commands plus the position (m_t) inside
  // the currently playing command, whose bus waveform is derived arithmetically.
  logic [11:0] m_q[$];
  logic [11:0] m_cur;
  bit          m_active;
  int          m_t;
  bit          m_rst_edge;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [3:0]  prev_d   = 4'd0;
  logic        prev_a0  = 1'b0;
  logic        prev_wr  = 1'b0;

  typedef struct packed {
    logic       v;
    logic [3:0] a;
    logic [7:0] dt;
    logic [3:0] ed;
    logic       ea0;
    logic       ewr;
    logic       eb;
    logic       er;
  } vec_t;

  vec_t tbl [0:14];

  function automatic vec_t mk(input logic v, input logic [3:0] a, input logic [7:0] dt,
                              input logic [3:0] ed, input logic ea0, input logic ewr,
                              input logic eb, input logic er);
    vec_t r;
    r.v = v; r.a = a; r.dt = dt; r.ed = ed; r.ea0 = ea0; r.ewr = ewr; r.eb = eb; r.er = er;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    bit acc;
    acc        = cmd_valid && (m_q.size() < DEPTH);
    m_rst_edge = !rst_n;
    if (!rst_n) begin
      m_q.delete();
      m_active = 1'b0;
      m_t      = 0;
    end else begin
      if (m_active && m_t < LEN - 1) begin
        m_t++;
      end else if (m_q.size() > 0) begin
        m_cur    = m_q.pop_front();
        m_t      = 0;
        m_active = 1'b1;
      end else begin
        m_active = 1'b0;
      end
      if (acc) m_q.push_back({cmd_addr, cmd_data});
    end
  endtask

  task automatic check_outputs();
    int         nib, sub;
    logic [3:0] ed;
    logic       ea0, ewr, eb, er;
    ed = 4'd0; ea0 = 1'b0; ewr = 1'b0;
    if (m_active) begin
      nib = m_t / (W + 2);
      sub = m_t % (W + 2);
      ewr = (sub >= 1) && (sub <= W);
      ea0 = (nib == 0);
      ed  = (nib == 0) ? m_cur[11:8] : (nib == 1) ? m_cur[3:0] : m_cur[7:4];
    end
    eb = m_active || (m_q.size() != 0);
    er = (m_q.size() < DEPTH);
    chk("d/a0/wr/busy/ready vs model", {bus_d, bus_a0, bus_wr, busy, cmd_ready},
        {ed, ea0, ewr, eb, er});
    // Bus must not move while strobing nor in the SETUP/HOLD cycles around it.
    if (!m_rst_edge && (bus_wr || prev_wr))
      chk("bus stable around strobe", {bus_a0, bus_d}, {prev_a0, prev_d});
    prev_d  = bus_d;
    prev_a0 = bus_a0;
    prev_wr = bus_wr;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  initial begin
    bit found;
    int p;
    int pw1, pw15, hi1, hi15, low1, low15;
    bit done1, done15;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = 4'd0; cmd_data = 8'd0; aux_valid = 1'b0;
    cycle();
    cycle();
    chk("reset bus_wr", bus_wr, 0);
    chk("reset busy", busy, 0);
    chk("reset ready", cmd_ready, 1);
    chk("reset a0/d", {bus_a0, bus_d}, 0);
    rst_n = 1'b1;
    cycle();

    // Single write 0x5 <- 0xA3, one row per cycle starting at the accept edge.
    tbl[0]  = mk(1, 4'h5, 8'hA3, 4'h0, 0, 0, 1, 1);
    tbl[1]  = mk(0, 4'h0, 8'h00, 4'h5, 1, 0, 1, 1);
    tbl[2]  = mk(0, 4'h0, 8'h00, 4'h5, 1, 1, 1, 1);
    tbl[3]  = mk(0, 4'h0, 8'h00, 4'h5, 1, 1, 1, 1);
    tbl[4]  = mk(0, 4'h0, 8'h00, 4'h5, 1, 0, 1, 1);
    tbl[5]  = mk(0, 4'h0, 8'h00, 4'h3, 0, 0, 1, 1);
    tbl[6]  = mk(0, 4'h0, 8'h00, 4'h3, 0, 1, 1, 1);
    tbl[7]  = mk(0, 4'h0, 8'h00, 4'h3, 0, 1, 1, 1);
    tbl[8]  = mk(0, 4'h0, 8'h00, 4'h3, 0, 0, 1, 1);
    tbl[9]  = mk(0, 4'h0, 8'h00, 4'hA, 0, 0, 1, 1);
    tbl[10] = mk(0, 4'h0, 8'h00, 4'hA, 0, 1, 1, 1);
    tbl[11] = mk(0, 4'h0, 8'h00, 4'hA, 0, 1, 1, 1);
    tbl[12] = mk(0, 4'h0, 8'h00, 4'hA, 0, 0, 1, 1);
    tbl[13] = mk(0, 4'h0, 8'h00, 4'h0, 0, 0, 0, 1);
    tbl[14] = mk(0, 4'h0, 8'h00, 4'h0, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++) begin
      cmd_valid = tbl[i].v;
      cmd_addr  = tbl[i].a;
      cmd_data  = tbl[i].dt;
      cycle();
      chk($sformatf("single-write vec%0d", i), {bus_d, bus_a0, bus_wr, busy, cmd_ready},
          {tbl[i].ed, tbl[i].ea0, tbl[i].ewr, tbl[i].eb, tbl[i].er});
    end

    // Fill: hold CMD_VALID high until the FIFO is full and beyond.
    cmd_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cmd_addr = 4'(i + 1);
      cmd_data = 8'($urandom);
      cycle();
    end
    chk("fill ready low when full", cmd_ready, 0);
    cmd_valid = 1'b0;
    repeat (70) cycle();
    chk("fill drained busy", busy, 0);

    // Reset during the NI1 strobe with two commands still queued.
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_addr = 4'($urandom);
      cmd_data = 8'($urandom);
      cycle();
    end
    cmd_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (bus_wr && m_active && (m_t / (W + 2)) == 1) found = 1'b1;
      else cycle();
    end
    chk("reached NI1 strobe", found, 1);
    rst_n = 1'b0;
    cycle();
    chk("mid-strobe reset bus_wr", bus_wr, 0);
    chk("mid-strobe reset busy", busy, 0);
    chk("mid-strobe reset a0/d", {bus_a0, bus_d}, 0);
    rst_n = 1'b1;
    repeat (20) cycle();
    chk("no replay after reset", busy, 0);

    // Randomised traffic, alternating light and heavy load, rare resets.
    for (int ph = 0; ph < 4; ph++) begin
      p = (ph % 2 == 1) ? 90 : 25;
      for (int i = 0; i < 250; i++) begin
        cmd_valid = ($urandom_range(0, 99) < p);
        cmd_addr  = 4'($urandom);
        cmd_data  = 8'($urandom);
        rst_n     = ($urandom_range(0, 499) != 0);
        cycle();
      end
    end
    rst_n = 1'b1; cmd_valid = 1'b0;
    repeat (80) cycle();
    chk("random drained busy", busy, 0);

    // Strobe width and command duration at WR_WIDTH = 1 and 15.
    aux_valid = 1'b1;
    cycle();
    aux_valid = 1'b0;
    pw1 = 0; pw15 = 0; hi1 = 0; hi15 = 0; low1 = -1; low15 = -1; done1 = 0; done15 = 0;
    for (int k = 1; k <= 80; k++) begin
      cycle();
      if (w1_wr) begin hi1++; if (!done1) pw1++; end else if (pw1 > 0) done1 = 1'b1;
      if (w15_wr) begin hi15++; if (!done15) pw15++; end else if (pw15 > 0) done15 = 1'b1;
      if (!w1_busy && low1 < 0) low1 = k;
      if (!w15_busy && low15 < 0) low15 = k;
    end
    chk("W1 pulse width", pw1, 1);
    chk("W15 pulse width", pw15, 15);
    chk("W1 strobe cycles", hi1, 3);
    chk("W15 strobe cycles", hi15, 45);
    chk("W1 command duration", low1 - 1, 9);
    chk("W15 command duration", low15 - 1, 51);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
